// File: rtl/ram_bcd_display.sv
// Synchronous RAM whose selected or auto-scanned word is converted to BCD by a
// multi-cycle shift-add-3 engine and shown on active-low 7-segment digits.
module ram_bcd_display #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 5,
    parameter int DIGITS   = 3,
    parameter int LZB      = 1,
    parameter int SCAN_GAP = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wren,
    input  logic [ADDR_W-1:0]     wraddress,
    input  logic [DATA_W-1:0]     data,
    input  logic [ADDR_W-1:0]     rdaddress,
    input  logic                  rd_req,
    input  logic                  scan_en,
    output logic [DATA_W-1:0]     q,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  ovf,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     cur_addr
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;

    typedef enum logic [2:0] {IDLE, RD, LD, SH, OUT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   scan_addr;
    logic [GAP_W-1:0]    gap;
    logic [CNT_W-1:0]    cnt;
    logic                ovf_acc;
    logic [DATA_W-1:0]   shreg;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic [7*DIGITS-1:0] hex_next;

    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign busy    = (state != IDLE);
    assign bcd_adj = dabble_adjust(bcd);

    // Walk digits from the top; blanking stops at the first nonzero digit or at units.
    always_comb begin
        logic lead;
        hex_next = '1;
        lead     = (LZB != 0);
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (ovf_acc) begin
                hex_next[7*i +: 7] = 7'b1111110;
            end else if (lead && i != 0 && bcd[4*i +: 4] == 4'd0) begin
                hex_next[7*i +: 7] = 7'b1111111;
            end else begin
                hex_next[7*i +: 7] = seg_decode(bcd[4*i +: 4]);
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wren) mem[wraddress] <= data;
    end

    // Conversion datapath: loaded in LD, shifted once per SH cycle.
    always_ff @(posedge clock) begin
        if (state == LD) begin
            shreg <= q;
            bcd   <= '0;
        end else if (state == SH) begin
            {bcd, shreg} <= {bcd_adj[BCD_W-2:0], shreg, 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            q         <= '0;
            hex       <= '1;
            ovf       <= 1'b0;
            done      <= 1'b0;
            cur_addr  <= '0;
            scan_addr <= '0;
            gap       <= '0;
            addr      <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (gap != '0) gap <= gap - 1'b1;
                    if (rd_req) begin
                        addr  <= rdaddress;
                        state <= RD;
                    end else if (scan_en && gap == '0) begin
                        addr      <= scan_addr;
                        scan_addr <= scan_addr + 1'b1;
                        state     <= RD;
                    end
                end
                RD: begin
                    q     <= mem[addr];
                    state <= LD;
                end
                LD: begin
                    ovf_acc <= 1'b0;
                    cnt     <= '0;
                    state   <= SH;
                end
                SH: begin
                    // A one leaving the top nibble means the value needs another digit.
                    if (bcd_adj[BCD_W-1]) ovf_acc <= 1'b1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) state <= OUT;
                end
                OUT: begin
                    hex      <= hex_next;
                    ovf      <= ovf_acc;
                    cur_addr <= addr;
                    done     <= 1'b1;
                    gap      <= GAP_W'(SCAN_GAP);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bcd_display.sv
// Directed bench for ram_bcd_display: four parameter variants share write and
// read-address stimulus; display values are hand-computed digit patterns.
module tb_ram_bcd_display;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S5 = 7'b0100100, S7 = 7'b0001111,
                           S9 = 7'b0000100, SB = 7'b1111111, SD = 7'b1111110;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, wren, rd_req, rd_req_s, scan_en_s;
    logic [4:0] wraddress, rdaddress;
    logic [7:0] data;

    logic [7:0]  q_a, q_b, q_c, q_s;
    logic [20:0] hex_a, hex_b, hex_s;
    logic [13:0] hex_c;
    logic        ovf_a, ovf_b, ovf_c, ovf_s;
    logic        busy_a, busy_b, busy_c, busy_s;
    logic        done_a, done_b, done_c, done_s;
    logic [4:0]  cur_a, cur_b, cur_c, cur_s;

    ram_bcd_display u_a (
        .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress), .data(data),
        .rdaddress(rdaddress), .rd_req(rd_req), .scan_en(1'b0), .q(q_a), .hex(hex_a),
        .ovf(ovf_a), .busy(busy_a), .done(done_a), .cur_addr(cur_a));

    ram_bcd_display #(.LZB(0)) u_b (
        .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress), .data(data),
        .rdaddress(rdaddress), .rd_req(rd_req), .scan_en(1'b0), .q(q_b), .hex(hex_b),
        .ovf(ovf_b), .busy(busy_b), .done(done_b), .cur_addr(cur_b));

    ram_bcd_display #(.DIGITS(2)) u_c (
        .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress), .data(data),
        .rdaddress(rdaddress), .rd_req(rd_req), .scan_en(1'b0), .q(q_c), .hex(hex_c),
        .ovf(ovf_c), .busy(busy_c), .done(done_c), .cur_addr(cur_c));

    ram_bcd_display #(.SCAN_GAP(2)) u_s (
        .clock(clock), .reset(reset), .wren(wren), .wraddress(wraddress), .data(data),
        .rdaddress(rdaddress), .rd_req(rd_req_s), .scan_en(scan_en_s), .q(q_s), .hex(hex_s),
        .ovf(ovf_s), .busy(busy_s), .done(done_s), .cur_addr(cur_s));

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic write_word(input logic [4:0] a, input logic [7:0] d);
        wren = 1'b1; wraddress = a; data = d;
        @(posedge clock); #1;
        wren = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output int lat);
        rd_req = 1'b1; rdaddress = a;
        @(posedge clock); #1;
        rd_req = 1'b0;
        chk("busy_after_req", busy_a, 1);
        lat = 0;
        do begin @(posedge clock); #1; lat++; end while (!done_a && lat < 40);
        chk("done_seen", done_a, 1);
    endtask

    task automatic wait_done_s(output int n);
        n = 0;
        do begin @(posedge clock); #1; n++; end while (!done_s && n < 40);
        chk("scan_done_seen", done_s, 1);
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic [7:0]  val;
        logic [20:0] hex_lzb;
        logic [20:0] hex_all;
        logic [13:0] hex_d2;
        logic        ovf_d2;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, pulses, cap_lat;
        logic [7:0]  cap_q;
        logic [20:0] cap_hex;

        vecs[0] = '{5'd3, 8'd173, {S1, S7, S3}, {S1, S7, S3}, {SD, SD}, 1'b1};
        vecs[1] = '{5'd0, 8'd0,   {SB, SB, S0}, {S0, S0, S0}, {SB, S0}, 1'b0};
        vecs[2] = '{5'd1, 8'd5,   {SB, SB, S5}, {S0, S0, S5}, {SB, S5}, 1'b0};
        vecs[3] = '{5'd2, 8'd255, {S2, S5, S5}, {S2, S5, S5}, {SD, SD}, 1'b1};
        vecs[4] = '{5'd4, 8'd99,  {SB, S9, S9}, {S0, S9, S9}, {S9, S9}, 1'b0};
        vecs[5] = '{5'd5, 8'd100, {S1, S0, S0}, {S1, S0, S0}, {SD, SD}, 1'b1};
        vecs[6] = '{5'd6, 8'd10,  {SB, S1, S0}, {S0, S1, S0}, {S1, S0}, 1'b0};
        vecs[7] = '{5'd8, 8'd207, {S2, S0, S7}, {S2, S0, S7}, {SD, SD}, 1'b1};

        reset = 1'b1; wren = 1'b0; rd_req = 1'b0; rd_req_s = 1'b0; scan_en_s = 1'b0;
        wraddress = '0; rdaddress = '0; data = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_q", q_a, 0);
        chk("rst_hex", hex_a, 21'h1FFFFF);
        chk("rst_hex_d2", hex_c, 14'h3FFF);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_cur", cur_a, 0);
        chk("rst_busy_scan", busy_s, 0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) write_word(5'(i), 8'(i));

        // Scan across the whole memory and wrap once.
        scan_en_s = 1'b1;
        for (int p = 0; p < 33; p++) begin
            wait_done_s(n);
            if (p > 0) chk("scan_period", n, 14);
            chk("scan_cur_addr", cur_s, p % 32);
            chk("scan_q", q_s, p % 32);
        end
        rd_req_s = 1'b1; rdaddress = 5'd7;
        @(posedge clock); #1;
        rd_req_s = 1'b0;
        wait_done_s(n);
        chk("scan_req_latency", n, 11);
        chk("scan_req_cur", cur_s, 7);
        chk("scan_req_q", q_s, 7);
        wait_done_s(n);
        chk("scan_resume_period", n, 14);
        chk("scan_resume_cur", cur_s, 1);
        scan_en_s = 1'b0;

        for (int v = 0; v < 8; v++) begin
            write_word(vecs[v].addr, vecs[v].val);
            do_read(vecs[v].addr, lat);
            chk("latency", lat, 11);
            chk("busy_at_done", busy_a, 0);
            chk("q", q_a, vecs[v].val);
            chk("cur_addr", cur_a, vecs[v].addr);
            chk("hex_lzb", hex_a, vecs[v].hex_lzb);
            chk("ovf_lzb", ovf_a, 0);
            chk("hex_no_lzb", hex_b, vecs[v].hex_all);
            chk("hex_d2", hex_c, vecs[v].hex_d2);
            chk("ovf_d2", ovf_c, vecs[v].ovf_d2);
        end

        // Same-address write during RD, plus request pulses while busy.
        rd_req = 1'b1; rdaddress = 5'd9;
        @(posedge clock); #1;
        rd_req = 1'b0; wren = 1'b1; wraddress = 5'd9; data = 8'd200;
        chk("rdw_busy", busy_a, 1);
        @(posedge clock); #1;
        wren = 1'b0;
        pulses = 0; cap_lat = 0; cap_q = '0; cap_hex = '0;
        for (int i = 2; i <= 24; i++) begin
            rd_req = (i == 4 || i == 7);
            @(posedge clock); #1;
            if (done_a) begin
                pulses++; cap_lat = i; cap_q = q_a; cap_hex = hex_a;
            end
        end
        rd_req = 1'b0;
        chk("busy_req_single_done", pulses, 1);
        chk("rdw_latency", cap_lat, 11);
        chk("rdw_old_q", cap_q, 9);
        chk("rdw_old_hex", cap_hex, {SB, SB, S9});
        do_read(5'd9, lat);
        chk("rdw_new_q", q_a, 200);
        chk("rdw_new_hex", hex_a, {S2, S0, S0});

        // Reset during SH aborts the conversion.
        rd_req = 1'b1; rdaddress = 5'd4;
        @(posedge clock); #1;
        rd_req = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("busy_in_sh", busy_a, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_hex", hex_a, 21'h1FFFFF);
        chk("abort_done", done_a, 0);
        chk("abort_q", q_a, 0);
        chk("abort_cur", cur_a, 0);
        pulses = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done_a) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        do_read(5'd4, lat);
        chk("post_abort_latency", lat, 11);
        chk("post_abort_q", q_a, 99);
        chk("post_abort_hex", hex_a, {SB, S9, S9});
        chk("post_abort_cur", cur_a, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ram_bcd_display.md
# ram_bcd_display

Parametrised RAM-plus-decimal-display block for the DE2 lab designs. It holds a synchronous single-port-write / single-port-read memory. A requested or auto-scanned word is read and converted to BCD by an iterative shift-add-3 (double-dabble) engine, then driven onto DIGITS active-low 7-segment displays. It replaces the fixed 8-bit, two-digit, combinational `%10` / `/10` path with a multi-cycle converter, overflow indication, leading-zero blanking and an address-scan mode.

## Interface
- DATA_W, 8: memory word width and conversion input width (≥1).
- ADDR_W, 5: address width; depth = 2^ADDR_W.
- DIGITS, 3: number of decimal digits displayed (≥1).
- LZB, 1: 1 = blank leading zero digits; 0 = show all zeros.
- SCAN_GAP, 0: idle cycles inserted between consecutive scan reads.

Ports:
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: reset, synchronous, active-high.
- wren, in, 1: write enable.
- wraddress, in, ADDR_W: write address.
- data, in, DATA_W: write data.
- rdaddress, in, ADDR_W: read address for explicit requests.
- rd_req, in, 1: explicit read-and-display request (level-sampled).
- scan_en, in, 1: enable automatic sequential read/display.
- q, out, DATA_W: last word read from memory (registered).
- hex, out, 7*DIGITS: segment fields.
  - Digit i (i=0 is units) occupies bits [7i+6:7i].
  - Bit 7i+6 is segment a, bit 7i+0 is segment g.
  - Active low.
- ovf, out, 1: displayed value exceeded 10^DIGITS−1.
- busy, out, 1: state ≠ IDLE (combinational from state).
- done, out, 1: one-cycle pulse when hex/ovf update.
- cur_addr, out, ADDR_W: address of the value currently displayed.

## Operation
- Write: when wren=1, mem[wraddress] ← data at the edge.
  - Writes are accepted in every state, including busy.
  - Memory is not cleared by reset.
- Read: synchronous.
  - Read-during-write to the same address returns the old data.
- FSM states: IDLE, RD, LD, SH, OUT.
- IDLE:
  - If rd_req=1: latch rdaddress into the address register, go to RD.
  - Else if scan_en=1 and the gap counter is 0: latch scan_addr, increment scan_addr, go to RD.
    - scan_addr wraps from 2^ADDR_W−1 to 0.
  - rd_req has priority over scan; scan_addr is unaffected by explicit reads.
- RD: q ← mem[addr]; go to LD.
- LD: shift register ← q, BCD accumulator (4*DIGITS bits) ← 0, ovf_acc ← 0, bit counter ← 0; go to SH.
- SH: runs for exactly DATA_W cycles.
  - Each cycle: add 3 to every BCD nibble ≥5, then shift {bcd, shreg} left by one.
  - If the bit shifted out of the top nibble is 1, set ovf_acc.
  - After the DATA_W-th shift, go to OUT.
- OUT: update the outputs, then go to IDLE.
  - hex ← decoded BCD; ovf ← ovf_acc; cur_addr ← addr; done ← 1.
  - Reload the gap counter with SCAN_GAP.
- Gap counter decrements by 1 per cycle in IDLE while nonzero.
- rd_req and scan_en are ignored while busy. A request held high is re-serviced once the FSM returns to IDLE.
- Digit decode, active low, a..g order:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111
- LZB=1: digits above the most significant nonzero digit are blank; digit 0 is never blanked (value 0 shows "0").
- Overflow: when ovf_acc=1, every digit shows dash 1111110 and ovf=1, regardless of LZB.

## Timing
- Reset values:
  - state=IDLE, q=0, hex all 1 (blank), ovf=0, done=0, busy=0.
  - cur_addr=0, scan_addr=0, gap counter=0.
- Request latency: request sampled at edge k → done=1 in the cycle after edge k+DATA_W+3. hex, ovf and cur_addr change at that same edge.
  - Total conversion = DATA_W+4 cycles.
- busy is high for the cycles following edges k .. k+DATA_W+2.
- done is high for exactly one cycle, coincident with the return to IDLE. A new request can be sampled at the edge ending the done cycle.
- Scan period = DATA_W+4+SCAN_GAP cycles per address while scan_en is held.
- Reset asserted mid-conversion: abort at that edge; all reset values apply the next cycle; no done pulse.
- A write to the latched address during RD is not seen (old data); a write during LD/SH does not affect the value being converted.

## Test plan
- Write 173 to addr 3, then rd_req with rdaddress=3 (defaults): done 12 cycles later; q=173; hex digit2=1001111, digit1=0001111, digit0=0000110; ovf=0; cur_addr=3.
- Write 0 and 5 to addr 0 and 1, read each (LZB=1): digit0=0000001 and 0100100 respectively; digits 1–2 = 1111111. Repeat with LZB=0: digits 1–2 = 0000001.
- DIGITS=2, write 255, read: ovf=1, both digits 1111110. Then write 99, read: ovf=0, digits 0000100/0000100.
- scan_en=1, SCAN_GAP=2, addr n preloaded with n: done pulses every 14 cycles; cur_addr sequence 0,1,…,31,0; rd_req=1 mid-scan for addr 7 is serviced next, and the scan then resumes at the next scan address.
- Same-address write during RD returns the old value; rd_req pulses while busy are ignored (exactly one done pulse).
- reset asserted during SH: next cycle busy=0, hex blank, done never pulses; a fresh read then completes normally.
